// File: rtl/pipe_credit_adapter_pkg.sv
// Shared helpers for the credit adapter around a non-stalling pipeline.
// Holds the credit-counter width function used by the top and the FIFO.
package pipe_credit_adapter_pkg;

    // Bits needed to count 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_out_fifo.sv
// Ring-buffer result FIFO with explicit pointer wrap and sticky overflow.
// Ports: push/push_data in, pop in, head/empty/full/overflow out.
module pipe_out_fifo
    import pipe_credit_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = credit_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  do_push, do_pop;

    // Depth need not be a power of two, so wrap by compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

endmodule

// File: rtl/pipe_credit_adapter.sv
// Ready/valid wrapper for a fixed-latency non-stalling pipeline.
// Ports: in_* stream, pipe_* issue/result, out_* stream, credits, overflow.
module pipe_credit_adapter
    import pipe_credit_adapter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PIPE_LATENCY = 3,
    parameter int FIFO_DEPTH   = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                pipe_input_valid,
    output logic [DATA_WIDTH-1:0]               pipe_x,
    input  logic                                pipe_output_valid,
    input  logic [DATA_WIDTH-1:0]               pipe_out,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [credit_width(FIFO_DEPTH)-1:0] credits,
    output logic                                overflow
);

    localparam int CW = credit_width(FIFO_DEPTH);

    if (PIPE_LATENCY < 1 || FIFO_DEPTH < 1) begin : g_bad_params
        $error("pipe_credit_adapter: PIPE_LATENCY and FIFO_DEPTH must be >= 1");
    end

    logic [CW-1:0] credits_q, credits_d;
    logic          issue, pop, push;
    logic          fifo_empty;
    logic          unused_full;

    assign in_ready         = !rst && (credits_q != '0);
    assign issue            = in_valid && in_ready;
    assign pipe_input_valid = issue;
    assign pipe_x           = in_data;
    assign pop              = out_valid && out_ready;
    // Results arriving during reset belong to flushed issues.
    assign push             = pipe_output_valid && !rst;
    assign out_valid        = !fifo_empty;

    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !issue && credits_q != CW'(FIFO_DEPTH)) begin
            // Clamp guards against surplus results from a bad latency.
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CW'(FIFO_DEPTH);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign credits = credits_q;

    pipe_out_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(pipe_out),
        .pop      (pop),
        .head     (out_data),
        .empty    (fifo_empty),
        .full     (unused_full),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_pipe_credit_adapter.sv
// Bench for pipe_credit_adapter with a delay-line pipeline model.
// Directed and random stimulus checked against a transaction-level model.
module tb_pipe_credit_adapter;

    localparam int DW    = 32;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          pipe_input_valid;
    logic [DW-1:0] pipe_x;
    logic          pipe_output_valid;
    logic [DW-1:0] pipe_out;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    credits;
    logic          overflow;

    always #5 clk = ~clk;

    pipe_credit_adapter #(
        .DATA_WIDTH(DW), .PIPE_LATENCY(3), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_input_valid(pipe_input_valid), .pipe_x(pipe_x),
        .pipe_output_valid(pipe_output_valid), .pipe_out(pipe_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .credits(credits), .overflow(overflow)
    );

    // Delay-line pipeline; latency selectable between scenarios.
    int            lat = 3;
    logic          inj = 1'b0;
    logic [DW-1:0] inj_data = '0;
    logic [7:0]    pv_q;
    logic [DW-1:0] pd_q [8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
        end else begin
            pv_q <= {pv_q[6:0], pipe_input_valid};
            pd_q[0] <= pipe_x;
            for (int i = 1; i < 8; i++) pd_q[i] <= pd_q[i-1];
        end
    end

    assign pipe_output_valid = inj | pv_q[lat-1];
    assign pipe_out          = inj ? inj_data : pd_q[lat-1];

    // Reference model: credit pool, in-flight results, buffered results.
    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;

    ent_t          infl[$];
    logic [DW-1:0] fifo_m[$];
    int            credits_m = DEPTH;
    logic          ovf_m = 1'b0;
    int            cyc = 0;
    int            passed = 0;
    int            total = 0;
    int            obs_issue = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        infl.delete();
        fifo_m.delete();
        credits_m = DEPTH;
        ovf_m = 1'b0;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id,
                        input logic ordy, output bit acc);
        bit   iss, pp;
        ent_t e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        while (infl.size() != 0 && infl[0].rdy <= cyc) begin
            e = infl.pop_front();
            fifo_m.push_back(e.d);
        end
        iss = iv && (credits_m != 0);
        pp  = (fifo_m.size() != 0) && ordy;
        chk("in_ready", in_ready, credits_m != 0);
        chk("pipe_input_valid", pipe_input_valid, iss);
        chk("pipe_x", pipe_x, id);
        chk("credits", credits, credits_m);
        chk("overflow", overflow, ovf_m);
        chk("out_valid", out_valid, fifo_m.size() != 0);
        if (fifo_m.size() != 0) chk("out_data", out_data, fifo_m[0]);
        if (pipe_input_valid === 1'b1) obs_issue++;
        @(posedge clk);
        if (iss) begin
            e.d   = id;
            e.rdy = cyc + lat + 1;
            infl.push_back(e);
        end
        if (inj) begin
            if (fifo_m.size() == DEPTH && !pp) ovf_m = 1'b1;
            else fifo_m.push_back(inj_data);
        end
        if (pp) void'(fifo_m.pop_front());
        if (iss && !pp) credits_m--;
        if (pp && !iss && credits_m < DEPTH) credits_m++;
        acc = iss;
        cyc++;
        #1;
    endtask

    bit a;
    int n;
    int v;

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_pipe_valid", pipe_input_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_credits", credits, 3'd5);
        chk("rst_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;

        // Reset release and single beat.
        step(0, 0, 1, a);
        step(1, 32'h0000_0010, 1, a);
        repeat (6) step(0, 0, 1, a);

        // Stalled consumer, then drain.
        obs_issue = 0;
        for (int i = 0; i < 8; i++) step(1, 32'h100 + i, 0, a);
        chk("stall_accepts", obs_issue, 5);
        repeat (10) step(0, 0, 1, a);

        // Full throughput, 20 beats through a wrapping buffer.
        n = 0;
        v = 1;
        while (v <= 20 && n < 100) begin
            step(1, v, 1, a);
            if (a) v++;
            n++;
        end
        chk("tput_cycles", n, 20);
        repeat (6) step(0, 0, 1, a);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom,
                 $urandom_range(0, 9) < 7, a);
        end
        repeat (12) step(0, 0, 1, a);

        // Latency mismatch with a 6-cycle pipeline.
        lat = 6;
        for (int i = 0; i < 5; i++) step(1, 32'hA0 + i, 0, a);
        repeat (8) step(0, 0, 0, a);
        inj = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        step(0, 0, 0, a);
        inj = 1'b0;
        step(0, 0, 0, a);
        repeat (8) step(0, 0, 1, a);
        lat = 3;

        // Mid-stream reset with three buffered entries.
        for (int i = 0; i < 3; i++) step(1, 32'h300 + i, 0, a);
        repeat (5) step(0, 0, 0, a);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_in_ready", in_ready, 1'b0);
        chk("async_pipe_valid", pipe_input_valid, 1'b0);
        chk("async_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (4) step(0, 0, 1, a);
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), a);
        end
        repeat (10) step(0, 0, 1, a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
